// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU command sequencer.
// Holds widths, FSM state encoding, FunSel codes and the illegal-opcode decode.
package alu_seq_pkg;

  localparam int unsigned DataWidth   = 16;
  localparam int unsigned NumRegs     = 4;
  localparam int unsigned RegIdxWidth = 2;
  localparam int unsigned FunSelWidth = 5;
  localparam int unsigned FlagWidth   = 4;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StCapture
  } seq_state_e;

  localparam logic [FunSelWidth-1:0] FunPassA = 5'b00000;
  localparam logic [FunSelWidth-1:0] FunAdd   = 5'b00100;
  localparam logic [FunSelWidth-1:0] FunSub   = 5'b00110;
  localparam logic [FunSelWidth-1:0] FunSubB  = 5'b00111;
  localparam logic [FunSelWidth-1:0] FunIll0  = 5'b01110;
  localparam logic [FunSelWidth-1:0] FunIll1  = 5'b01111;
  localparam logic [FunSelWidth-1:0] FunIll2  = 5'b11110;
  localparam logic [FunSelWidth-1:0] FunIll3  = 5'b11111;

  // x1110 and x1111 are the unused FunSel codes.
  function automatic logic is_illegal_op(input logic [FunSelWidth-1:0] op);
    return op[3:1] == 3'b111;
  endfunction

endpackage

// File: rtl/seq_regfile.sv
// 4x16 register file: two combinational read ports and one write port where the
// sequencer writeback overrides a direct load to the same entry.
module seq_regfile
  import alu_seq_pkg::*;
(
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic [RegIdxWidth-1:0] RdSelA,
  input  logic [RegIdxWidth-1:0] RdSelB,
  output logic [DataWidth-1:0]   RdDataA,
  output logic [DataWidth-1:0]   RdDataB,
  input  logic                   WbEn,
  input  logic [RegIdxWidth-1:0] WbSel,
  input  logic [DataWidth-1:0]   WbData,
  input  logic                   LoadEn,
  input  logic [RegIdxWidth-1:0] LoadSel,
  input  logic [DataWidth-1:0]   LoadData
);

  logic [DataWidth-1:0] regs_q [NumRegs];

  always_ff @(posedge Clock) begin
    for (int i = 0; i < NumRegs; i++) begin
      if (Reset) begin
        regs_q[i] <= '0;
      end else if (WbEn && (WbSel == RegIdxWidth'(i))) begin
        regs_q[i] <= WbData;
      end else if (LoadEn && (LoadSel == RegIdxWidth'(i))) begin
        regs_q[i] <= LoadData;
      end
    end
  end

  assign RdDataA = regs_q[RdSelA];
  assign RdDataB = regs_q[RdSelB];

endmodule

// File: rtl/alu_command_sequencer.sv
// Sequences one register-file command through an external ALU:
// IDLE (accept + operand snapshot) -> ISSUE -> CAPTURE (writeback) -> Done pulse.
module alu_command_sequencer
  import alu_seq_pkg::*;
(
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   CmdValid,
  output logic                   CmdReady,
  input  logic [FunSelWidth-1:0] CmdOp,
  input  logic [RegIdxWidth-1:0] CmdDst,
  input  logic [RegIdxWidth-1:0] CmdSrcA,
  input  logic [RegIdxWidth-1:0] CmdSrcB,
  input  logic                   CmdSetFlags,
  input  logic                   LoadEn,
  input  logic [RegIdxWidth-1:0] LoadSel,
  input  logic [DataWidth-1:0]   LoadData,
  output logic [DataWidth-1:0]   ALUA,
  output logic [DataWidth-1:0]   ALUB,
  output logic [FunSelWidth-1:0] ALUFunSel,
  output logic                   ALUWF,
  input  logic [DataWidth-1:0]   ALUOut,
  input  logic [FlagWidth-1:0]   FlagsIn,
  output logic                   Done,
  output logic [DataWidth-1:0]   Result,
  output logic [FlagWidth-1:0]   FlagsSnap,
  output logic                   Error
);

  seq_state_e             state_q, state_d;
  logic [FunSelWidth-1:0] op_q;
  logic [RegIdxWidth-1:0] dst_q;
  logic                   setflags_q;
  logic [DataWidth-1:0]   opa_q, opb_q;
  logic [DataWidth-1:0]   rd_a, rd_b;
  logic [DataWidth-1:0]   result_q;
  logic [FlagWidth-1:0]   flags_q;
  logic                   done_q, error_q;
  logic                   accept, wb_en;

  assign accept = CmdValid && (state_q == StIdle);

  seq_regfile u_regfile (
    .Clock    (Clock),
    .Reset    (Reset),
    .RdSelA   (CmdSrcA),
    .RdSelB   (CmdSrcB),
    .RdDataA  (rd_a),
    .RdDataB  (rd_b),
    .WbEn     (wb_en),
    .WbSel    (dst_q),
    .WbData   (ALUOut),
    .LoadEn   (LoadEn),
    .LoadSel  (LoadSel),
    .LoadData (LoadData)
  );

  always_comb begin
    state_d   = state_q;
    CmdReady  = 1'b0;
    ALUA      = '0;
    ALUB      = '0;
    ALUFunSel = '0;
    ALUWF     = 1'b0;
    wb_en     = 1'b0;
    case (state_q)
      StIdle: begin
        CmdReady = 1'b1;
        // Illegal opcodes are consumed here and only raise Error.
        if (CmdValid && !is_illegal_op(CmdOp)) begin
          state_d = StIssue;
        end
      end
      StIssue: begin
        ALUA      = opa_q;
        ALUB      = opb_q;
        ALUFunSel = op_q;
        ALUWF     = setflags_q;
        state_d   = StCapture;
      end
      StCapture: begin
        ALUA      = opa_q;
        ALUB      = opb_q;
        ALUFunSel = op_q;
        wb_en     = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= StIdle;
      op_q       <= '0;
      dst_q      <= '0;
      setflags_q <= 1'b0;
      opa_q      <= '0;
      opb_q      <= '0;
      result_q   <= '0;
      flags_q    <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == StCapture);
      error_q <= accept && is_illegal_op(CmdOp);
      if (accept) begin
        op_q       <= CmdOp;
        dst_q      <= CmdDst;
        setflags_q <= CmdSetFlags;
        opa_q      <= rd_a;
        opb_q      <= rd_b;
      end
      if (wb_en) begin
        result_q <= ALUOut;
        flags_q  <= FlagsIn;
      end
    end
  end

  assign Done      = done_q;
  assign Error     = error_q;
  assign Result    = result_q;
  assign FlagsSnap = flags_q;

endmodule

// File: tb/tb_alu_command_sequencer.sv
// Self-checking bench: behavioural ALU, register-file model and a result
// scoreboard popped on each Done pulse.
module tb_alu_command_sequencer;
  import alu_seq_pkg::*;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        CmdValid, CmdReady, CmdSetFlags;
  logic [4:0]  CmdOp;
  logic [1:0]  CmdDst, CmdSrcA, CmdSrcB;
  logic        LoadEn;
  logic [1:0]  LoadSel;
  logic [15:0] LoadData;
  logic [15:0] ALUA, ALUB, ALUOut, Result;
  logic [4:0]  ALUFunSel;
  logic        ALUWF, Done, Error;
  logic [3:0]  FlagsIn, FlagsSnap;

  always #5 Clock = ~Clock;

  alu_command_sequencer dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .CmdValid    (CmdValid),
    .CmdReady    (CmdReady),
    .CmdOp       (CmdOp),
    .CmdDst      (CmdDst),
    .CmdSrcA     (CmdSrcA),
    .CmdSrcB     (CmdSrcB),
    .CmdSetFlags (CmdSetFlags),
    .LoadEn      (LoadEn),
    .LoadSel     (LoadSel),
    .LoadData    (LoadData),
    .ALUA        (ALUA),
    .ALUB        (ALUB),
    .ALUFunSel   (ALUFunSel),
    .ALUWF       (ALUWF),
    .ALUOut      (ALUOut),
    .FlagsIn     (FlagsIn),
    .Done        (Done),
    .Result      (Result),
    .FlagsSnap   (FlagsSnap),
    .Error       (Error)
  );

  // Returns {Z,C,N,O, result}.
  function automatic logic [19:0] alu_calc(input logic [4:0] op, input logic [15:0] a,
                                           input logic [15:0] b);
    logic [16:0] s;
    logic        c, o;
    c = 1'b0;
    o = 1'b0;
    case (op)
      FunAdd: begin
        s = {1'b0, a} + {1'b0, b};
        c = s[16];
        o = (a[15] == b[15]) && (s[15] != a[15]);
      end
      FunSub: begin
        s = {1'b0, a} - {1'b0, b};
        c = s[16];
        o = (a[15] != b[15]) && (s[15] != a[15]);
      end
      FunSubB: begin
        s = {1'b0, a} - {1'b0, b} - 17'd1;
        c = s[16];
      end
      default: s = {1'b0, a};
    endcase
    return {(s[15:0] == 16'h0), c, s[15], o, s[15:0]};
  endfunction

  logic [19:0] alu_now;
  logic [3:0]  alu_flags_q;
  assign alu_now = alu_calc(ALUFunSel, ALUA, ALUB);
  assign ALUOut  = alu_now[15:0];
  assign FlagsIn = alu_flags_q;

  always @(posedge Clock) begin
    if (Reset) alu_flags_q <= 4'h0;
    else if (ALUWF) alu_flags_q <= alu_now[19:16];
  end

  typedef struct {
    logic [15:0] res;
    logic [3:0]  flags;
    int          acc;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic [15:0] model_r [4];
  logic [3:0]  model_flags;
  logic [15:0] last_res;
  logic [3:0]  last_snap;
  logic [15:0] cur_a, cur_b;
  logic        err_exp = 1'b0;
  logic        isu_ld = 1'b0;
  logic [1:0]  isu_ld_sel = 2'd0;
  logic [15:0] isu_ld_data = 16'h0;

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge Clock) begin
    if (Done) begin
      check("done_err_excl", 32'(Error), 0);
      if (sb_q.size() == 0) begin
        check("done_unexpected", 32'(Done), 0);
      end else begin
        mon_e = sb_q.pop_front();
        check("result", 32'(Result), 32'(mon_e.res));
        check("flags_snap", 32'(FlagsSnap), 32'(mon_e.flags));
        check("latency", cyc, mon_e.acc + 3);
      end
    end
    if (Error && !err_exp) check("error_unexpected", 32'(Error), 0);
  end

  task automatic send(input logic [4:0] op, input logic [1:0] dst, input logic [1:0] srca,
                      input logic [1:0] srcb, input logic sf);
    exp_t        e;
    logic [19:0] rr;
    @(negedge Clock);
    check("cmd_ready", 32'(CmdReady), 1);
    CmdValid    = 1'b1;
    CmdOp       = op;
    CmdDst      = dst;
    CmdSrcA     = srca;
    CmdSrcB     = srcb;
    CmdSetFlags = sf;
    cur_a       = model_r[srca];
    cur_b       = model_r[srcb];
    @(posedge Clock);
    #1;
    CmdValid = 1'b0;
    err_exp  = is_illegal_op(op);
    if (!err_exp) begin
      rr = alu_calc(op, cur_a, cur_b);
      if (sf) model_flags = rr[19:16];
      model_r[dst] = rr[15:0];
      last_res     = rr[15:0];
      last_snap    = model_flags;
      e.res        = rr[15:0];
      e.flags      = model_flags;
      e.acc        = cyc - 1;
      sb_q.push_back(e);
    end
  endtask

  // Returns at the CAPTURE-cycle negedge so a following command lands in the Done cycle.
  task automatic run_cmd(input logic [4:0] op, input logic [1:0] dst, input logic [1:0] srca,
                         input logic [1:0] srcb, input logic sf);
    send(op, dst, srca, srcb, sf);
    if (is_illegal_op(op)) begin
      @(negedge Clock);
      check("err_pulse", 32'(Error), 1);
      check("err_wf", 32'(ALUWF), 0);
      check("err_ready", 32'(CmdReady), 1);
      check("err_result", 32'(Result), 32'(last_res));
      check("err_flags", 32'(FlagsSnap), 32'(last_snap));
      @(posedge Clock);
      #1;
      err_exp = 1'b0;
    end else begin
      @(negedge Clock);
      check("issue_a", 32'(ALUA), 32'(cur_a));
      check("issue_b", 32'(ALUB), 32'(cur_b));
      check("issue_fun", 32'(ALUFunSel), 32'(op));
      check("issue_wf", 32'(ALUWF), 32'(sf));
      check("issue_ready", 32'(CmdReady), 0);
      if (isu_ld) begin
        LoadEn   = 1'b1;
        LoadSel  = isu_ld_sel;
        LoadData = isu_ld_data;
      end
      @(negedge Clock);
      if (isu_ld) begin
        LoadEn = 1'b0;
        if (isu_ld_sel != dst) model_r[isu_ld_sel] = isu_ld_data;
      end
      check("cap_a", 32'(ALUA), 32'(cur_a));
      check("cap_b", 32'(ALUB), 32'(cur_b));
      check("cap_fun", 32'(ALUFunSel), 32'(op));
      check("cap_wf", 32'(ALUWF), 0);
    end
  endtask

  task automatic read_reg(input logic [1:0] idx);
    run_cmd(FunPassA, idx, idx, idx, 1'b0);
  endtask

  task automatic load(input logic [1:0] sel, input logic [15:0] data);
    @(negedge Clock);
    LoadEn   = 1'b1;
    LoadSel  = sel;
    LoadData = data;
    @(posedge Clock);
    #1;
    LoadEn       = 1'b0;
    model_r[sel] = data;
  endtask

  task automatic settle();
    repeat (3) @(negedge Clock);
  endtask

  task automatic clear_model();
    for (int i = 0; i < 4; i++) model_r[i] = 16'h0;
    model_flags = 4'h0;
    last_res    = 16'h0;
    last_snap   = 4'h0;
  endtask

  logic [4:0] ill_ops [4];

  initial begin
    ill_ops[0] = FunIll0;
    ill_ops[1] = FunIll1;
    ill_ops[2] = FunIll2;
    ill_ops[3] = FunIll3;
    Reset = 1'b1; CmdValid = 1'b0; CmdOp = 5'h0; CmdDst = 2'd0; CmdSrcA = 2'd0;
    CmdSrcB = 2'd0; CmdSetFlags = 1'b0; LoadEn = 1'b0; LoadSel = 2'd0; LoadData = 16'h0;
    clear_model();
    repeat (2) @(posedge Clock);
    #1;
    Reset = 1'b0;
    @(negedge Clock);
    check("rst_ready", 32'(CmdReady), 1);
    check("rst_done", 32'(Done), 0);
    check("rst_error", 32'(Error), 0);
    check("rst_alua", 32'(ALUA), 0);
    check("rst_alub", 32'(ALUB), 0);
    check("rst_fun", 32'(ALUFunSel), 0);
    check("rst_wf", 32'(ALUWF), 0);
    check("rst_result", 32'(Result), 0);
    check("rst_flags", 32'(FlagsSnap), 0);

    // Signed overflow add: 0x7FFF + 1.
    load(2'd0, 16'h7FFF);
    load(2'd1, 16'h0001);
    run_cmd(FunAdd, 2'd2, 2'd0, 2'd1, 1'b1);
    settle();
    read_reg(2'd2);

    // Back-to-back with a dependency on the just-written register.
    settle();
    load(2'd0, 16'd5);
    load(2'd1, 16'd3);
    run_cmd(FunAdd, 2'd2, 2'd0, 2'd1, 1'b1);
    run_cmd(FunSub, 2'd3, 2'd2, 2'd1, 1'b1);
    settle();
    read_reg(2'd3);

    // Illegal opcodes: Error only, nothing written.
    settle();
    for (int i = 0; i < 4; i++) run_cmd(ill_ops[i], 2'(i), 2'd1, 2'd2, 1'b1);
    for (int i = 0; i < 4; i++) read_reg(2'(i));

    // Load on the CAPTURE edge of a write to the same register loses.
    settle();
    load(2'd0, 16'h00F0);
    load(2'd1, 16'h000F);
    run_cmd(FunAdd, 2'd2, 2'd0, 2'd1, 1'b0);
    LoadEn   = 1'b1;
    LoadSel  = 2'd2;
    LoadData = 16'h1234;
    @(posedge Clock);
    #1;
    LoadEn = 1'b0;
    settle();
    read_reg(2'd2);

    // SetFlags=0 keeps the flags from the previous flag-writing command.
    settle();
    run_cmd(FunSub, 2'd3, 2'd1, 2'd0, 1'b1);
    run_cmd(FunSubB, 2'd3, 2'd0, 2'd1, 1'b0);

    // Load into a source register after accept must not disturb the snapshot.
    settle();
    isu_ld      = 1'b1;
    isu_ld_sel  = 2'd0;
    isu_ld_data = 16'hAAAA;
    run_cmd(FunAdd, 2'd3, 2'd0, 2'd1, 1'b0);
    isu_ld = 1'b0;
    settle();
    read_reg(2'd0);
    read_reg(2'd3);

    // Reset during ISSUE drops the command.
    settle();
    load(2'd0, 16'd1);
    load(2'd1, 16'd2);
    send(FunAdd, 2'd2, 2'd0, 2'd1, 1'b1);
    @(negedge Clock);
    check("pre_rst_fun", 32'(ALUFunSel), 32'(FunAdd));
    Reset = 1'b1;
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    sb_q.delete();
    clear_model();
    @(negedge Clock);
    check("midrst_ready", 32'(CmdReady), 1);
    check("midrst_alua", 32'(ALUA), 0);
    check("midrst_wf", 32'(ALUWF), 0);
    check("midrst_result", 32'(Result), 0);
    settle();
    read_reg(2'd2);

    settle();
    check("sb_drain", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_command_sequencer.md
ALU_COMMAND_SEQUENCER -- requirements
Module: alu_command_sequencer

Interface
REQ-001 The block SHALL have no parameters; the data width is fixed at 16 bits and the register file holds 4 entries (R0..R3).
REQ-002 Clock  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 Reset  in  1  synchronous, active-high reset.
REQ-004 CmdValid  in  1  command present.
REQ-005 CmdReady  out  1  the block accepts a command when CmdValid and CmdReady are both 1 on a rising edge.
REQ-006 CmdOp  in  5  ALU function select, FunSel encoding.
REQ-007 CmdDst / CmdSrcA / CmdSrcB  in  2 each  destination and source register indices.
REQ-008 CmdSetFlags  in  1  1 = the ALU flags SHALL be updated for this command.
REQ-009 LoadEn / LoadSel / LoadData  in  1 / 2 / 16  direct register-file write port.
REQ-010 ALUA / ALUB  out  16  ALU operands.
REQ-011 ALUFunSel  out  5  ALU function select.
REQ-012 ALUWF  out  1  ALU flag write enable.
REQ-013 ALUOut  in  16  combinational ALU result.
REQ-014 FlagsIn  in  4  ALU registered flags, ordered {Z,C,N,O}.
REQ-015 Done  out  1  one-cycle completion pulse.
REQ-016 Result  out  16  captured result.
REQ-017 FlagsSnap  out  4  captured flags.
REQ-018 Error  out  1  one-cycle pulse on an illegal opcode.

Function
REQ-019 The FSM SHALL have three states, IDLE, ISSUE and CAPTURE; CmdReady SHALL be 1 only in IDLE.
REQ-020 On accept, the block SHALL latch CmdOp, CmdDst and CmdSetFlags, and SHALL snapshot R[CmdSrcA] and R[CmdSrcB]; the FSM SHALL then go IDLE->ISSUE.
REQ-021 In ISSUE:
- ALUA and ALUB SHALL carry the snapshot values and ALUFunSel SHALL carry the latched opcode.
- ALUWF SHALL equal the latched CmdSetFlags.
- The FSM SHALL go ISSUE->CAPTURE.
REQ-022 In CAPTURE:
- Operands and FunSel SHALL be held and ALUWF SHALL be 0.
- At the closing edge the block SHALL register Result<=ALUOut and FlagsSnap<=FlagsIn, and write ALUOut into R[dst].
- The FSM SHALL go CAPTURE->IDLE and Done SHALL be 1 in the following cycle.
REQ-023 Latency SHALL be exactly 3 cycles from the accept edge to Done high; maximum throughput SHALL be 1 command per 3 cycles.
REQ-024 A command accepted in the cycle in which Done is high SHALL read the already-written destination value; no bypass path is permitted.
REQ-025 Opcodes 01110, 01111, 11110 and 11111 SHALL be accepted, then handled as follows:
- Error SHALL pulse in the next cycle with no ISSUE or CAPTURE.
- ALUWF SHALL stay 0.
- No register write SHALL occur, and Result and FlagsSnap SHALL be unchanged.
REQ-026 In IDLE, ALUA, ALUB and ALUFunSel SHALL be 0 and ALUWF SHALL be 0.
REQ-027 LoadEn SHALL write LoadData into R[LoadSel] in any state; if it targets the writeback register on the CAPTURE edge, the writeback SHALL win.
REQ-028 A load that occurs after accept SHALL NOT alter the already-snapshotted operands.
REQ-029 Done and Error SHALL never be high in the same cycle.

Reset
REQ-030 When Reset is 1 at an edge:
- The FSM SHALL return to IDLE.
- R0..R3, Result and FlagsSnap SHALL be cleared to 0.
- Done, Error and ALUWF SHALL be 0.
- Any in-flight command SHALL be dropped with no writeback.
REQ-031 Reset SHALL take priority over LoadEn and over command accept.

Structure
REQ-032 The shared package alu_seq_pkg SHALL hold the state enumeration, named FunSel constants, the illegal-opcode function, and the width and register-count constants.
REQ-033 The block SHALL contain one sub-module, seq_regfile: 4x16 entries, 2 combinational read ports, and 1 write port with a writeback-over-load priority mux.

Verification
REQ-034 R0=0x7FFF, R1=0x0001, op 00100, dst R2, SetFlags=1:
- ISSUE shows A=0x7FFF, B=0x0001, WF=1.
- Done comes 3 cycles after accept, with Result=0x8000, R2=0x8000, FlagsSnap=4'b0011.
REQ-035 Back-to-back: cmd1 R2=R0+R1 (5+3); cmd2 (00110, R3=R2-R1) accepted in the Done cycle -> R3=0x0005.
REQ-036 op 01110 -> Error pulses 1 cycle after accept, ALUWF stays 0, R0..R3 unchanged, next command accepted normally.
REQ-037 Reset asserted during ISSUE -> next cycle IDLE, CmdReady=1, Done never pulses, dst reads 0x0000.
REQ-038 LoadEn to R2 with 0x1234 on the CAPTURE edge of a write to R2 (result 0x00FF) -> R2=0x00FF.
REQ-039 SetFlags=0 with op 00111 -> ALUWF stays 0 throughout, and FlagsSnap equals the FlagsIn value present before the command.
